// File: rtl/frame_strobe_sequencer_if.sv
// Handshake and frame bus between the bitstream front-end (master) and the
// column frame strobe sequencer (slave).
interface frame_strobe_sequencer_if #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumRows         = 16
) ();
    localparam int unsigned FrameW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

    logic                               cmd_valid;
    logic                               cmd_ready;
    logic [FrameW-1:0]                  cmd_frame;
    logic                               wr_valid;
    logic                               wr_ready;
    logic [FrameBitsPerRow-1:0]         wr_data;
    logic [NumRows*FrameBitsPerRow-1:0] FrameData;
    logic [MaxFramesPerCol-1:0]         FrameStrobe;
    logic                               busy;
    logic                               err;
    logic [15:0]                        frame_count;

    // Front-end side: issues commands and row words.
    modport master (
        output cmd_valid, cmd_frame, wr_valid, wr_data,
        input  cmd_ready, wr_ready, FrameData, FrameStrobe, busy, err, frame_count
    );

    // Sequencer side: drives the column frame bus.
    modport slave (
        input  cmd_valid, cmd_frame, wr_valid, wr_data,
        output cmd_ready, wr_ready, FrameData, FrameStrobe, busy, err, frame_count
    );
endinterface

// File: rtl/frame_strobe_sequencer.sv
// Column configuration sequencer: takes a frame command, collects one word per
// tile row into FrameData, waits a setup window, pulses the one-hot FrameStrobe
// line for the frame, then holds FrameData one extra cycle before going idle.
module frame_strobe_sequencer #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumRows         = 16,
    parameter int unsigned SetupCycles     = 1,
    parameter int unsigned StrobeWidth     = 1
) (
    input logic                     UserCLK,
    input logic                     resetn,
    frame_strobe_sequencer_if.slave bus
);
    localparam int unsigned FrameW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int unsigned RowW   = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned DlyMax = (SetupCycles > StrobeWidth) ? SetupCycles : StrobeWidth;
    localparam int unsigned DlyW   = (DlyMax > 1) ? $clog2(DlyMax) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e                             state_q;
    logic [FrameW-1:0]                  frame_q;
    logic [RowW-1:0]                    row_q;
    logic [DlyW-1:0]                    dly_q;
    logic [NumRows*FrameBitsPerRow-1:0] frame_data_q;
    logic [MaxFramesPerCol-1:0]         strobe_q;
    logic                               err_q;
    logic [15:0]                        frame_count_q;

    // Sequencer FSM with registered strobe, data, error and counter outputs.
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q       <= StIdle;
            frame_q       <= '0;
            row_q         <= '0;
            dly_q         <= '0;
            frame_data_q  <= '0;
            strobe_q      <= '0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        if (int'(bus.cmd_frame) < int'(MaxFramesPerCol)) begin
                            frame_q <= bus.cmd_frame;
                            row_q   <= '0;
                            state_q <= StLoad;
                        end else begin
                            // Out-of-range frame: flag it and drop the command.
                            err_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (bus.wr_valid) begin
                        for (int r = 0; r < int'(NumRows); r++) begin
                            if (row_q == RowW'(r)) begin
                                frame_data_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= bus.wr_data;
                            end
                        end
                        if (row_q == RowW'(NumRows - 1)) begin
                            row_q   <= '0;
                            dly_q   <= '0;
                            state_q <= StSetup;
                        end else begin
                            row_q <= row_q + RowW'(1);
                        end
                    end
                end
                StSetup: begin
                    if (dly_q == DlyW'(SetupCycles - 1)) begin
                        dly_q <= '0;
                        for (int f = 0; f < int'(MaxFramesPerCol); f++) begin
                            strobe_q[f] <= (frame_q == FrameW'(f));
                        end
                        state_q <= StStrobe;
                    end else begin
                        dly_q <= dly_q + DlyW'(1);
                    end
                end
                StStrobe: begin
                    if (dly_q == DlyW'(StrobeWidth - 1)) begin
                        dly_q    <= '0;
                        strobe_q <= '0;
                        state_q  <= StHold;
                    end else begin
                        dly_q <= dly_q + DlyW'(1);
                    end
                end
                StHold: begin
                    if (frame_count_q != 16'hFFFF) begin
                        frame_count_q <= frame_count_q + 16'd1;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q  <= StIdle;
                    strobe_q <= '0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.wr_ready    = (state_q == StLoad);
    assign bus.busy        = (state_q != StIdle);
    assign bus.FrameData   = frame_data_q;
    assign bus.FrameStrobe = strobe_q;
    assign bus.err         = err_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer: NumRows=4, 20 frames, setup 1, strobe 2.
module tb_frame_strobe_sequencer;
    localparam int unsigned MaxFrames = 20;
    localparam int unsigned RowBits   = 32;
    localparam int unsigned Rows      = 4;
    localparam int unsigned Setup     = 1;
    localparam int unsigned StrobeW   = 2;

    logic UserCLK = 1'b0;
    logic resetn  = 1'b0;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    frame_strobe_sequencer_if #(
        .MaxFramesPerCol (MaxFrames),
        .FrameBitsPerRow (RowBits),
        .NumRows         (Rows)
    ) bus ();

    frame_strobe_sequencer #(
        .MaxFramesPerCol (MaxFrames),
        .FrameBitsPerRow (RowBits),
        .NumRows         (Rows),
        .SetupCycles     (Setup),
        .StrobeWidth     (StrobeW)
    ) dut (
        .UserCLK (UserCLK),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    // Command plus four back-to-back words; leaves the DUT just after the last-word edge.
    task automatic load_frame(input logic [4:0] f, input logic [127:0] words);
        bus.cmd_valid = 1'b1;
        bus.cmd_frame = f;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = words[i*32 +: 32];
            step();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_frame = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        step();
        step();
        resetn = 1'b1;
        step();
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++;
            $display("FAIL reset_cmd_ready got=%0h exp=1", bus.cmd_ready); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++;
            $display("FAIL reset_wr_ready got=%0h exp=0", bus.wr_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.FrameStrobe !== 20'h0) begin failures++;
            $display("FAIL reset_strobe got=%0h exp=0", bus.FrameStrobe); end
        checks++; if (bus.FrameData !== 128'h0) begin failures++;
            $display("FAIL reset_data got=%0h exp=0", bus.FrameData); end
        checks++; if (bus.frame_count !== 16'h0) begin failures++;
            $display("FAIL reset_count got=%0h exp=0", bus.frame_count); end
        checks++; if (bus.err !== 1'b0) begin failures++;
            $display("FAIL reset_err got=%0h exp=0", bus.err); end
    endtask

    task automatic test_single_frame();
        logic [127:0] exp_data;
        exp_data = 128'h44444444_33333333_22222222_11111111;
        bus.cmd_valid = 1'b1;
        bus.cmd_frame = 5'd5;
        step();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.wr_ready !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_load_state got wr=%0h cmd=%0h busy=%0h exp 1/0/1",
                     bus.wr_ready, bus.cmd_ready, bus.busy); end
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = exp_data[i*32 +: 32];
            step();
        end
        bus.wr_valid = 1'b0;
        // Setup cycle
        checks++; if (bus.FrameData !== exp_data) begin failures++;
            $display("FAIL single_data got=%0h exp=%0h", bus.FrameData, exp_data); end
        checks++; if (bus.FrameStrobe !== 20'h0 || bus.wr_ready !== 1'b0) begin failures++;
            $display("FAIL single_setup got strobe=%0h wr=%0h exp 0/0",
                     bus.FrameStrobe, bus.wr_ready); end
        step();
        checks++; if (bus.FrameStrobe !== 20'h00020) begin failures++;
            $display("FAIL single_strobe1 got=%0h exp=00020", bus.FrameStrobe); end
        step();
        checks++; if (bus.FrameStrobe !== 20'h00020) begin failures++;
            $display("FAIL single_strobe2 got=%0h exp=00020", bus.FrameStrobe); end
        step();
        // Hold cycle
        checks++; if (bus.FrameStrobe !== 20'h0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0)
        begin failures++;
            $display("FAIL single_hold got strobe=%0h busy=%0h cmd=%0h exp 0/1/0",
                     bus.FrameStrobe, bus.busy, bus.cmd_ready); end
        checks++; if (bus.frame_count !== 16'd0 || bus.FrameData !== exp_data) begin failures++;
            $display("FAIL single_hold_data got count=%0h data=%0h exp 0/%0h",
                     bus.frame_count, bus.FrameData, exp_data); end
        step();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++;
            $display("FAIL single_idle got cmd=%0h busy=%0h exp 1/0", bus.cmd_ready, bus.busy); end
        checks++; if (bus.frame_count !== 16'd1) begin failures++;
            $display("FAIL single_count got=%0h exp=1", bus.frame_count); end
    endtask

    task automatic test_toggle();
        int unsigned hits, bad, early_ready;
        logic [127:0] exp_data;
        exp_data    = 128'hA0000006_A0000004_A0000002_A0000000;
        hits        = 0;
        bad         = 0;
        early_ready = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_frame = 5'd19;
        step();
        for (int c = 0; c < 10; c++) begin
            bus.wr_valid = (c % 2 == 0);
            bus.wr_data  = 32'hA000_0000 + 32'(c);
            step();
            if (bus.FrameStrobe == 20'h80000) hits++;
            else if (bus.FrameStrobe != 20'h0) bad++;
            if (bus.cmd_ready) early_ready++;
        end
        checks++; if (bus.busy !== 1'b1) begin failures++;
            $display("FAIL toggle_hold_busy got=%0h exp=1", bus.busy); end
        checks++; if (bus.FrameData !== exp_data) begin failures++;
            $display("FAIL toggle_data got=%0h exp=%0h", bus.FrameData, exp_data); end
        checks++; if (hits !== 2 || bad !== 0) begin failures++;
            $display("FAIL toggle_strobe got hits=%0d bad=%0d exp 2/0", hits, bad); end
        checks++; if (early_ready !== 0) begin failures++;
            $display("FAIL toggle_cmd_ready got=%0d exp=0", early_ready); end
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b0 || bus.frame_count !== 16'd2) begin failures++;
            $display("FAIL toggle_done got busy=%0h count=%0h exp 0/2",
                     bus.busy, bus.frame_count); end
    endtask

    task automatic test_err();
        logic [127:0] exp_data;
        exp_data = 128'hA0000006_A0000004_A0000002_A0000000;
        bus.cmd_valid = 1'b1;
        bus.cmd_frame = 5'd20;
        step();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.err !== 1'b1) begin failures++;
            $display("FAIL err_pulse got=%0h exp=1", bus.err); end
        checks++; if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_state got busy=%0h wr=%0h cmd=%0h exp 0/0/1",
                     bus.busy, bus.wr_ready, bus.cmd_ready); end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hDEADBEEF;
        step();
        bus.wr_valid = 1'b0;
        checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin failures++;
            $display("FAIL err_clear got err=%0h busy=%0h exp 0/0", bus.err, bus.busy); end
        checks++; if (bus.FrameData !== exp_data) begin failures++;
            $display("FAIL err_data got=%0h exp=%0h", bus.FrameData, exp_data); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] words;
        words = 128'h00000004_00000003_00000002_00000001;
        // Reset after two words
        bus.cmd_valid = 1'b1;
        bus.cmd_frame = 5'd7;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'hCAFE0000 + 32'(i);
            step();
        end
        bus.wr_valid = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++; if (bus.FrameData !== 128'h0 || bus.FrameStrobe !== 20'h0) begin failures++;
            $display("FAIL rstload_out got data=%0h strobe=%0h exp 0/0",
                     bus.FrameData, bus.FrameStrobe); end
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstload_state got busy=%0h cmd=%0h wr=%0h exp 0/1/0",
                     bus.busy, bus.cmd_ready, bus.wr_ready); end
        // Reset during second strobe cycle
        load_frame(5'd9, 128'h55555555_66666666_77777777_88888888);
        step();
        step();
        checks++; if (bus.FrameStrobe !== 20'h00200) begin failures++;
            $display("FAIL rststrobe_pre got=%0h exp=00200", bus.FrameStrobe); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++; if (bus.FrameStrobe !== 20'h0 || bus.FrameData !== 128'h0) begin failures++;
            $display("FAIL rststrobe_out got strobe=%0h data=%0h exp 0/0",
                     bus.FrameStrobe, bus.FrameData); end
        checks++; if (bus.busy !== 1'b0 || bus.frame_count !== 16'd0) begin failures++;
            $display("FAIL rststrobe_state got busy=%0h count=%0h exp 0/0",
                     bus.busy, bus.frame_count); end
        // Frame 3 afterwards completes normally
        load_frame(5'd3, words);
        step();
        checks++; if (bus.FrameStrobe !== 20'h00008) begin failures++;
            $display("FAIL after_rst_strobe got=%0h exp=00008", bus.FrameStrobe); end
        step();
        step();
        step();
        checks++; if (bus.frame_count !== 16'd1 || bus.FrameData !== words || bus.busy !== 1'b0)
        begin failures++;
            $display("FAIL after_rst_done got count=%0h busy=%0h data=%0h exp 1/0/%0h",
                     bus.frame_count, bus.busy, bus.FrameData, words); end
    endtask

    task automatic test_saturate();
        force dut.frame_count_q = 16'hFFFE;
        step();
        release dut.frame_count_q;
        step();
        checks++; if (bus.frame_count !== 16'hFFFE) begin failures++;
            $display("FAIL sat_preload got=%0h exp=FFFE", bus.frame_count); end
        load_frame(5'd0, 128'h1);
        step(); step(); step(); step();
        checks++; if (bus.frame_count !== 16'hFFFF) begin failures++;
            $display("FAIL sat_first got=%0h exp=FFFF", bus.frame_count); end
        load_frame(5'd1, 128'h2);
        step(); step(); step(); step();
        checks++; if (bus.frame_count !== 16'hFFFF || bus.busy !== 1'b0) begin failures++;
            $display("FAIL sat_second got count=%0h busy=%0h exp FFFF/0",
                     bus.frame_count, bus.busy); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_toggle();
        test_err();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
